tm1640_refresh_ctrl: RTL and testbench
======================================

Name: tm1640_refresh_ctrl

Overview:
Frame scheduler in front of the TM1640 display driver.
- Holds a NUM_DIGITS-byte segment frame buffer written by the host.
- Decides when to push a full frame: on a dirty buffer, on a brightness or on/off change, on the periodic refresh timer, or on an explicit request.
- Streams the frame and the three command bytes into the driver's load interface, then tracks driver completion with a watchdog.

Parameters:
NUM_DIGITS, 16, frame bytes per transfer (1..16); also sent as the driver byte count.
REFRESH_CYCLES, 5000000, clk cycles between forced refreshes; 0 disables periodic refresh.
TIMEOUT_CYCLES, 1000000, max cycles to wait for drv_done before aborting.
HOLDOFF_CYCLES, 16, idle gap enforced after each transfer; minimum 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  host frame-buffer write strobe
wr_addr  in  4  frame byte index; writes with wr_addr>=NUM_DIGITS are ignored
wr_data  in  8  segment byte
bright  in  3  brightness level 0..7
disp_on  in  1  display enable
refresh_req  in  1  single-cycle request for an immediate frame push
busy  out  1  high from trigger accept until HOLDOFF ends
frame_cnt  out  16  completed transfers, wraps
err_timeout  out  1  sticky; set on watchdog expiry, cleared only by rst
drv_tvalid  out  1  driver load strobe
drv_tdata  out  8  driver load byte
drv_send_bytes  out  8  constant NUM_DIGITS
drv_cmd1  out  8  constant 8'h40 (auto-increment write)
drv_cmd2  out  8  constant 8'hC0 (start address 0)
drv_cmd3  out  8  {4'b1000, disp_on_l, bright_l}
drv_done  in  1  driver idle flag (low while transferring)

Behaviour:
Reset values and clock/reset rules:
- One clock, clk. rst is synchronous and active-high.
- Reset values: busy=0, frame_cnt=0, err_timeout=0, drv_tvalid=0, drv_tdata=0, state=IDLE, dirty=1 so the first frame after reset is pushed.
- Refresh timer restarts at 0.
- Buffer contents are not reset.

Buffer and latches:
- wr_en with a valid address writes the buffer and sets dirty, in every state.
- A write during STREAM to an index not yet streamed is included in the current frame. dirty still stays set, so the frame is re-sent.
- bright/disp_on are sampled into bright_l/disp_on_l only in IDLE when a trigger is accepted; drv_cmd3 is stable for the whole transfer.
- A difference between the live inputs and the latched values counts as dirty.

Triggers:
- A trigger is any of: dirty, refresh_req, or timer==REFRESH_CYCLES-1.
- refresh_req arriving while not in IDLE is latched as pending and served after HOLDOFF.
- The timer counts in every state and clears on trigger acceptance.

State machine: IDLE, STREAM, WAIT_START, WAIT_DONE, HOLDOFF.
- IDLE:
  - Waits for a trigger with drv_done=1.
  - On accept: clear dirty/pending, latch cmd3 fields, busy=1, go STREAM.
- STREAM:
  - drv_tvalid=1 for exactly NUM_DIGITS+1 consecutive cycles.
  - Stream cycle 0 and cycle 1: drv_tdata=buf[0].
  - Stream cycle k+1 (k=1..NUM_DIGITS-1): drv_tdata=buf[k].
  - The next cycle drops drv_tvalid and goes to WAIT_START.
- WAIT_START: waits for drv_done=0, then goes to WAIT_DONE.
- WAIT_DONE: waits for drv_done=1; then frame_cnt+=1 and go to HOLDOFF.
- Watchdog:
  - A counter spans WAIT_START+WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: set err_timeout, set dirty, go to HOLDOFF.
  - frame_cnt is not incremented on timeout.
- HOLDOFF: HOLDOFF_CYCLES cycles with drv_tvalid=0, then busy=0 and go to IDLE.

Other rules:
- drv_tvalid never rises twice within one transfer. It always has at least HOLDOFF_CYCLES low cycles between transfers, which guarantees a clean rising edge at the driver.
- rst mid-transfer: drv_tvalid drops the next cycle. The driver may finish its in-flight transfer; the first post-reset trigger waits for drv_done=1.

Test Plan:
- Reset, buffer preloaded 0x00..0x0F, bright=3, disp_on=1 -> one transfer:
  - drv_tvalid high 17 cycles, tdata sequence 00,00,01,...,0F.
  - drv_cmd3=8'h8B.
  - frame_cnt=1 after drv_done returns high; busy low HOLDOFF_CYCLES cycles later.
- Idle with REFRESH_CYCLES=100 and no writes -> a transfer starts every 100 cycles (±transfer length), with identical byte streams.
- Write wr_addr=5, wr_data=0x7F during WAIT_DONE -> the current frame is unaffected; exactly one more transfer follows HOLDOFF carrying buf[5]=0x7F.
- Change bright 3->7 and disp_on 1->0 while idle -> a transfer starts with drv_cmd3=8'h87.
- Model driver never drops drv_done with TIMEOUT_CYCLES=50 -> err_timeout=1 after 50 cycles, frame_cnt unchanged, retry transfer after HOLDOFF.
- Assert rst during STREAM cycle 4 -> drv_tvalid=0 next cycle, outputs at reset values, new transfer only after drv_done=1.

Source files
------------

// File: rtl/tm1640_refresh_ctrl.sv
// Frame scheduler for the TM1640 driver: holds the segment buffer, decides when a
// full frame must be pushed, streams it into the driver load port and watches for completion.
module tm1640_refresh_ctrl #(
   parameter int NUM_DIGITS     = 16,
   parameter int REFRESH_CYCLES = 5000000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int HOLDOFF_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [7:0]  wr_data,
   input  logic [2:0]  bright,
   input  logic        disp_on,
   input  logic        refresh_req,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic        err_timeout,
   output logic        drv_tvalid,
   output logic [7:0]  drv_tdata,
   output logic [7:0]  drv_send_bytes,
   output logic [7:0]  drv_cmd1,
   output logic [7:0]  drv_cmd2,
   output logic [7:0]  drv_cmd3,
   input  logic        drv_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT_START,
      S_WAIT_DONE,
      S_HOLDOFF
   } state_t;

   localparam bit          TIMER_EN = (REFRESH_CYCLES > 0);
   localparam logic [31:0] REF_LAST = 32'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
   localparam logic [31:0] WD_LAST  = 32'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [31:0] HO_LAST  = 32'((HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES - 1 : 1);
   localparam logic [4:0]  IDX_LAST = 5'(NUM_DIGITS);

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] wd_q, wd_d;
   logic [31:0] ho_q, ho_d;
   logic        dirty_q, dirty_d;
   logic        pend_q, pend_d;
   logic [2:0]  bright_l_q, bright_l_d;
   logic        disp_on_l_q, disp_on_l_d;
   logic        busy_q, busy_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        err_q, err_d;
   logic        tvalid_q, tvalid_d;
   logic [7:0]  tdata_q, tdata_d;

   logic [7:0]  fb_q [NUM_DIGITS];
   logic        wr_ok;
   logic [3:0]  rd_idx;
   logic [7:0]  rd_byte;
   logic        dirty_eff;
   logic        timer_hit;
   logic        trigger;
   logic        wd_expired;

   assign wr_ok = wr_en && ({1'b0, wr_addr} < 5'(NUM_DIGITS));

   // A write landing on the byte being fetched this cycle is forwarded into the stream.
   assign rd_idx  = (state_q == S_STREAM) ? idx_q[3:0] : 4'd0;
   assign rd_byte = (wr_ok && (wr_addr == rd_idx)) ? wr_data : fb_q[rd_idx];

   assign dirty_eff  = dirty_q || (bright != bright_l_q) || (disp_on != disp_on_l_q);
   assign timer_hit  = TIMER_EN && (timer_q == REF_LAST);
   assign trigger    = dirty_eff || pend_q || refresh_req || timer_hit;
   assign wd_expired = (wd_q >= WD_LAST);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         fb_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      timer_d     = timer_q;
      wd_d        = wd_q;
      ho_d        = ho_q;
      dirty_d     = dirty_q;
      pend_d      = pend_q;
      bright_l_d  = bright_l_q;
      disp_on_l_d = disp_on_l_q;
      busy_d      = busy_q;
      frame_cnt_d = frame_cnt_q;
      err_d       = err_q;
      tvalid_d    = tvalid_q;
      tdata_d     = tdata_q;

      if (refresh_req) begin
         pend_d = 1'b1;
      end
      // The timer parks on its last value so a refresh due while busy is served afterwards.
      if (TIMER_EN && (timer_q != REF_LAST)) begin
         timer_d = timer_q + 32'd1;
      end

      case (state_q)
         S_IDLE: begin
            tvalid_d = 1'b0;
            if (trigger && drv_done) begin
               dirty_d     = 1'b0;
               pend_d      = 1'b0;
               bright_l_d  = bright;
               disp_on_l_d = disp_on;
               busy_d      = 1'b1;
               timer_d     = 32'd0;
               idx_d       = 5'd0;
               tvalid_d    = 1'b1;
               tdata_d     = rd_byte;
               state_d     = S_STREAM;
            end
         end
         S_STREAM: begin
            if (idx_q == IDX_LAST) begin
               tvalid_d = 1'b0;
               wd_d     = 32'd0;
               state_d  = S_WAIT_START;
            end else begin
               tdata_d = rd_byte;
               idx_d   = idx_q + 5'd1;
            end
         end
         S_WAIT_START: begin
            if (!drv_done) begin
               wd_d    = wd_q + 32'd1;
               state_d = S_WAIT_DONE;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               dirty_d = 1'b1;
               ho_d    = 32'd0;
               state_d = S_HOLDOFF;
            end else begin
               wd_d = wd_q + 32'd1;
            end
         end
         S_WAIT_DONE: begin
            if (drv_done) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               ho_d        = 32'd0;
               state_d     = S_HOLDOFF;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               dirty_d = 1'b1;
               ho_d    = 32'd0;
               state_d = S_HOLDOFF;
            end else begin
               wd_d = wd_q + 32'd1;
            end
         end
         S_HOLDOFF: begin
            if (ho_q >= HO_LAST) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               ho_d = ho_q + 32'd1;
            end
         end
         default: begin
            tvalid_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
      endcase

      // Host writes mark the frame stale even if they also made it into the current stream.
      if (wr_ok) begin
         dirty_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= 5'd0;
         timer_q     <= 32'd0;
         wd_q        <= 32'd0;
         ho_q        <= 32'd0;
         dirty_q     <= 1'b1;
         pend_q      <= 1'b0;
         bright_l_q  <= 3'd0;
         disp_on_l_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= 16'd0;
         err_q       <= 1'b0;
         tvalid_q    <= 1'b0;
         tdata_q     <= 8'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         timer_q     <= timer_d;
         wd_q        <= wd_d;
         ho_q        <= ho_d;
         dirty_q     <= dirty_d;
         pend_q      <= pend_d;
         bright_l_q  <= bright_l_d;
         disp_on_l_q <= disp_on_l_d;
         busy_q      <= busy_d;
         frame_cnt_q <= frame_cnt_d;
         err_q       <= err_d;
         tvalid_q    <= tvalid_d;
         tdata_q     <= tdata_d;
      end
   end

   assign busy           = busy_q;
   assign frame_cnt      = frame_cnt_q;
   assign err_timeout    = err_q;
   assign drv_tvalid     = tvalid_q;
   assign drv_tdata      = tdata_q;
   assign drv_send_bytes = 8'(NUM_DIGITS);
   assign drv_cmd1       = 8'h40;
   assign drv_cmd2       = 8'hC0;
   assign drv_cmd3       = {4'b1000, disp_on_l_q, bright_l_q};

endmodule

// File: tb/tb_tm1640_refresh_ctrl.sv
// Bench for tm1640_refresh_ctrl: a model driver plus a frame-level reference of what
// each pushed frame must contain, when it must appear, and what the status outputs show.
module tb_tm1640_refresh_ctrl;
   localparam int ND = 16;
   localparam int RC = 100;
   localparam int TC = 50;
   localparam int HC = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, wr_en, disp_on, refresh_req, drv_done;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [2:0]  bright;
   logic        busy, err_timeout, drv_tvalid;
   logic [15:0] frame_cnt;
   logic [7:0]  drv_tdata, drv_send_bytes, drv_cmd1, drv_cmd2, drv_cmd3;

   tm1640_refresh_ctrl #(
      .NUM_DIGITS(ND), .REFRESH_CYCLES(RC), .TIMEOUT_CYCLES(TC), .HOLDOFF_CYCLES(HC)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .bright(bright), .disp_on(disp_on), .refresh_req(refresh_req), .busy(busy),
      .frame_cnt(frame_cnt), .err_timeout(err_timeout), .drv_tvalid(drv_tvalid),
      .drv_tdata(drv_tdata), .drv_send_bytes(drv_send_bytes), .drv_cmd1(drv_cmd1),
      .drv_cmd2(drv_cmd2), .drv_cmd3(drv_cmd3), .drv_done(drv_done)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mfb [ND];
   logic [7:0] cap_bytes [32];
   int         cap_len, cap_wait, cap_start, prev_start, exp_fc;
   bit         cap_ok, cap_cmd3_stable;
   logic [7:0] cap_cmd3;
   bit         drv_stuck = 1'b0;

   // Model driver: goes busy two cycles after the load strobe falls, idle again later.
   initial begin
      int len;
      drv_done = 1'b1;
      forever begin
         wait (drv_tvalid === 1'b1);
         @(negedge drv_tvalid);
         if (!drv_stuck) begin
            len = $urandom_range(20, 5);
            repeat (2) @(posedge clk);
            #1 drv_done = 1'b0;
            repeat (len) @(posedge clk);
            #1 drv_done = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation ran past its time limit");
      $fatal(1);
   end

   function automatic logic [7:0] exp_cmd3(input logic [2:0] b, input logic on);
      return {4'b1000, on, b};
   endfunction

   // Expected frame: byte 0 twice, then bytes 1..ND-1 of the host buffer.
   function automatic int frame_diff();
      int n = 0;
      for (int k = 0; k <= ND; k++) begin
         if (cap_bytes[k] !== mfb[(k == 0) ? 0 : k - 1]) n++;
      end
      return n;
   endfunction

   task automatic capture_frame(input int bound);
      cap_ok = 1'b0; cap_len = 0; cap_wait = 0; cap_cmd3_stable = 1'b1;
      while (drv_tvalid !== 1'b1 && cap_wait < bound) begin
         @(negedge clk);
         cap_wait++;
      end
      if (drv_tvalid === 1'b1) begin
         cap_cmd3  = drv_cmd3;
         cap_start = cyc;
         while (drv_tvalid === 1'b1 && cap_len < 32) begin
            cap_bytes[cap_len] = drv_tdata;
            if (drv_cmd3 !== cap_cmd3) cap_cmd3_stable = 1'b0;
            cap_len++;
            @(negedge clk);
         end
         cap_ok = 1'b1;
      end
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d; mfb[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_req();
      refresh_req = 1'b1;
      @(negedge clk);
      refresh_req = 1'b0;
   endtask

   task automatic wait_not_busy(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 150) begin @(negedge clk); n++; end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: busy=%b expected 0", tag, busy); end
   endtask

   task automatic check_frame(input string tag, input logic [7:0] cmd3_exp);
      checks++;
      if (!cap_ok || cap_len !== ND + 1) begin
         errors++; $display("FAIL %s_len: got ok=%b len=%0d expected len %0d", tag, cap_ok, cap_len, ND + 1);
      end
      checks++;
      if (frame_diff() != 0) begin
         errors++; $display("FAIL %s_bytes: got %0d wrong bytes expected 0", tag, frame_diff());
      end
      checks++;
      if (cap_cmd3 !== cmd3_exp || !cap_cmd3_stable) begin
         errors++; $display("FAIL %s_cmd3: got %h stable=%b expected %h", tag, cap_cmd3, cap_cmd3_stable, cmd3_exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
      bright = 3'd3; disp_on = 1'b1; refresh_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
      checks++; if (drv_tvalid !== 1'b0 || drv_tdata !== 8'd0) begin
         errors++; $display("FAIL reset_drv: got tvalid=%b tdata=%h expected 0/00", drv_tvalid, drv_tdata);
      end
      checks++; if (drv_send_bytes !== 8'(ND) || drv_cmd1 !== 8'h40 || drv_cmd2 !== 8'hC0) begin
         errors++; $display("FAIL const_cmds: got %h %h %h expected %h 40 c0", drv_send_bytes, drv_cmd1, drv_cmd2, 8'(ND));
      end
      for (int i = 0; i < ND; i++) host_write(4'(i), 8'(i));
   endtask

   task automatic test_first_frame();
      int n;
      rst = 1'b0;
      capture_frame(5);
      check_frame("first", 8'h8B);
      prev_start = cap_start;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b expected 1", busy); end
      n = 0;
      while (drv_done !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      while (drv_done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      checks++; if (frame_cnt !== 16'd0 || drv_done !== 1'b1) begin
         errors++; $display("FAIL first_cnt_early: got cnt=%0d done=%b expected 0/1", frame_cnt, drv_done);
      end
      @(negedge clk);
      exp_fc = 1;
      checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL first_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
      n = 0;
      while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
      checks++; if (n != HC) begin errors++; $display("FAIL first_holdoff: got %0d cycles expected %0d", n, HC); end
   endtask

   task automatic test_periodic();
      for (int f = 0; f < 2; f++) begin
         capture_frame(150);
         check_frame("periodic", 8'h8B);
         checks++;
         if (cap_start - prev_start < 90 || cap_start - prev_start > 160) begin
            errors++; $display("FAIL periodic_gap: got %0d cycles expected about %0d", cap_start - prev_start, RC);
         end
         prev_start = cap_start;
         wait_not_busy("periodic");
         exp_fc++;
         checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL periodic_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
      end
   endtask

   task automatic test_write_during_wait();
      int n;
      bit seen;
      capture_frame(150);
      check_frame("wwait_cur", 8'h8B);
      prev_start = cap_start;
      n = 0;
      while (drv_done !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      host_write(4'd5, 8'h7F);
      capture_frame(60);
      check_frame("wwait_next", 8'h8B);
      checks++; if (cap_bytes[6] !== 8'h7F) begin errors++; $display("FAIL wwait_byte5: got %h expected 7f", cap_bytes[6]); end
      checks++; if (cap_start - prev_start >= 90) begin
         errors++; $display("FAIL wwait_gap: got %0d cycles expected under 90", cap_start - prev_start);
      end
      prev_start = cap_start;
      wait_not_busy("wwait");
      exp_fc += 2;
      checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL wwait_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin @(negedge clk); if (drv_tvalid === 1'b1) seen = 1'b1; end
      checks++; if (seen) begin errors++; $display("FAIL wwait_extra: got an extra transfer expected none"); end
   endtask

   task automatic test_bright_change();
      bright = 3'd7; disp_on = 1'b0;
      capture_frame(3);
      check_frame("bright", 8'h87);
      checks++; if (cap_wait > 2) begin errors++; $display("FAIL bright_latency: got %0d cycles expected <=2", cap_wait); end
      prev_start = cap_start;
      wait_not_busy("bright");
      exp_fc++;
      checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL bright_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
   endtask

   task automatic test_random();
      int n, act, a_start;
      bit trig;
      logic [2:0] nb;
      logic non;
      for (int it = 0; it < 6; it++) begin
         pulse_req();
         capture_frame(4);
         check_frame("rand_a", exp_cmd3(bright, disp_on));
         a_start = cap_start;
         n = 0;
         while (drv_done !== 1'b0 && n < 10) begin @(negedge clk); n++; end
         act = $urandom_range(3, 0);
         trig = 1'b0;
         if (act == 1) begin
            for (int w = 0; w < int'($urandom_range(2, 1)); w++) host_write(4'($urandom_range(15, 0)), 8'($urandom));
            trig = 1'b1;
         end else if (act == 2) begin
            nb = 3'($urandom); non = 1'($urandom);
            trig = (nb != bright) || (non != disp_on);
            bright = nb; disp_on = non;
         end else if (act == 3) begin
            pulse_req();
            trig = 1'b1;
         end
         capture_frame(200);
         check_frame("rand_b", exp_cmd3(bright, disp_on));
         checks++;
         if (trig ? (cap_start - a_start >= 90) : (cap_start - a_start < 90 || cap_start - a_start > 160)) begin
            errors++; $display("FAIL rand_gap: got %0d cycles trig=%b act=%0d", cap_start - a_start, trig, act);
         end
         wait_not_busy("rand");
         exp_fc += 2;
         checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL rand_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
      end
   endtask

   task automatic test_timeout();
      int n;
      wait_not_busy("tmo_pre");
      drv_stuck = 1'b1;
      pulse_req();
      capture_frame(4);
      check_frame("tmo_frame", exp_cmd3(bright, disp_on));
      n = 0;
      while (err_timeout !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      drv_stuck = 1'b0;
      checks++; if (err_timeout !== 1'b1 || n < TC - 1 || n > TC + 1) begin
         errors++; $display("FAIL tmo_delay: got err=%b after %0d cycles expected 1 after %0d", err_timeout, n, TC);
      end
      checks++; if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL tmo_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
      capture_frame(30);
      check_frame("tmo_retry", exp_cmd3(bright, disp_on));
      wait_not_busy("tmo");
      exp_fc++;
      checks++; if (frame_cnt !== 16'(exp_fc) || err_timeout !== 1'b1) begin
         errors++; $display("FAIL tmo_after: got cnt=%0d err=%b expected %0d/1", frame_cnt, err_timeout, exp_fc);
      end
   endtask

   task automatic test_reset_mid_stream();
      int n, early;
      wait_not_busy("rmid_pre");
      pulse_req();
      checks++; if (drv_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_start: got tvalid=%b expected 1", drv_tvalid); end
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (drv_tvalid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0 || err_timeout !== 1'b0 || drv_tdata !== 8'd0) begin
         errors++; $display("FAIL rmid_reset: got tvalid=%b busy=%b cnt=%0d err=%b tdata=%h expected all 0",
                            drv_tvalid, busy, frame_cnt, err_timeout, drv_tdata);
      end
      n = 0;
      while (drv_done !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      rst = 1'b0;
      early = 0; n = 0;
      while (drv_done === 1'b0 && n < 40) begin
         @(negedge clk); n++;
         if (drv_tvalid === 1'b1) early++;
      end
      checks++; if (early != 0 || drv_done !== 1'b1) begin
         errors++; $display("FAIL rmid_wait_done: got %0d early strobe cycles done=%b expected 0/1", early, drv_done);
      end
      capture_frame(4);
      check_frame("rmid_frame", exp_cmd3(bright, disp_on));
      wait_not_busy("rmid");
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rmid_cnt: got %0d expected 1", frame_cnt); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_first_frame();
      test_periodic();
      test_write_during_wait();
      test_bright_change();
      test_random();
      test_timeout();
      test_reset_mid_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
